// File: rtl/pipe_hazard_ctrl.sv
// Hazard control for a five-stage pipeline: forwarding selects, load-use stall,
// stalls for the multi-cycle mul/div unit, and IF/ID flush on a taken branch.
module pipe_hazard_ctrl (
  input  logic       clk,
  input  logic       clrn,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       id_wreg,
  input  logic       id_m2reg,
  input  logic [4:0] id_wn,
  input  logic       id_mdu,
  input  logic       mdu_done,
  input  logic       branch_taken,
  output logic       stall,
  output logic       bubble,
  output logic       flush_if,
  output logic [1:0] fwda,
  output logic [1:0] fwdb,
  output logic       mdu_start
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state, state_nxt;
  logic       ex_wreg, ex_m2reg, mem_wreg, mem_m2reg;
  logic [4:0] ex_wn, mem_wn;
  logic       load_use;
  logic       stall_raw, bubble_raw, start_raw;
  logic [1:0] fwda_raw, fwdb_raw;

  // EX result has priority because it is the younger write to the register
  function automatic logic [1:0] fwd_sel(input logic use_r, input logic [4:0] r,
                                         input logic exw, input logic [4:0] exn,
                                         input logic memw, input logic [4:0] memn);
    logic [1:0] sel;
    sel = 2'b00;
    if (use_r && exw && (exn != 5'd0) && (exn == r))
      sel = 2'b01;
    else if (memw && (memn != 5'd0) && (memn == r))
      sel = 2'b10;
    return sel;
  endfunction

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ex_wreg   <= 1'b0;
      ex_m2reg  <= 1'b0;
      ex_wn     <= 5'd0;
      mem_wreg  <= 1'b0;
      mem_m2reg <= 1'b0;
      mem_wn    <= 5'd0;
    end else begin
      ex_wreg   <= bubble ? 1'b0 : id_wreg;
      ex_m2reg  <= bubble ? 1'b0 : id_m2reg;
      ex_wn     <= bubble ? 5'd0 : id_wn;
      mem_wreg  <= ex_wreg;
      mem_m2reg <= ex_m2reg;
      mem_wn    <= ex_wn;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= IDLE;
    else       state <= state_nxt;
  end

  assign load_use = ex_wreg & ex_m2reg & (ex_wn != 5'd0) &
                    ((id_use_rs & (id_rs == ex_wn)) | (id_use_rt & (id_rt == ex_wn)));

  assign fwda_raw = fwd_sel(id_use_rs, id_rs, ex_wreg, ex_wn, mem_wreg, mem_wn);
  assign fwdb_raw = fwd_sel(id_use_rt, id_rt, ex_wreg, ex_wn, mem_wreg, mem_wn);

  // A load-use stall in IDLE defers the mul/div start until the load reaches MEM
  always_comb begin
    state_nxt  = state;
    stall_raw  = 1'b0;
    bubble_raw = 1'b0;
    start_raw  = 1'b0;
    case (state)
      IDLE: begin
        if (load_use) begin
          stall_raw  = 1'b1;
          bubble_raw = 1'b1;
        end else if (id_mdu) begin
          start_raw  = 1'b1;
          stall_raw  = 1'b1;
          bubble_raw = 1'b1;
          state_nxt  = BUSY;
        end
      end
      BUSY: begin
        if (!mdu_done) begin
          stall_raw  = 1'b1;
          bubble_raw = 1'b1;
        end else begin
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are forced quiet while reset is held, whatever the inputs do
  assign stall     = clrn & stall_raw;
  assign bubble    = clrn & bubble_raw;
  assign mdu_start = clrn & start_raw;
  assign flush_if  = clrn & branch_taken & ~stall_raw;
  assign fwda      = clrn ? fwda_raw : 2'b00;
  assign fwdb      = clrn ? fwdb_raw : 2'b00;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: each stimulus pushes its hand-derived
// expected outputs, which are popped and compared just before the next rising edge.
module tb_pipe_hazard_ctrl;

  logic       clk, clrn;
  logic [4:0] id_rs, id_rt, id_wn;
  logic       id_use_rs, id_use_rt, id_wreg, id_m2reg;
  logic       id_mdu, mdu_done, branch_taken;
  logic       stall, bubble, flush_if, mdu_start;
  logic [1:0] fwda, fwdb;

  typedef struct {
    string      tag;
    logic [7:0] v;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   failures = 0;

  pipe_hazard_ctrl dut (
    .clk(clk), .clrn(clrn),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_wreg(id_wreg), .id_m2reg(id_m2reg), .id_wn(id_wn),
    .id_mdu(id_mdu), .mdu_done(mdu_done), .branch_taken(branch_taken),
    .stall(stall), .bubble(bubble), .flush_if(flush_if),
    .fwda(fwda), .fwdb(fwdb), .mdu_start(mdu_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
                       input logic wreg, input logic m2r, input logic [4:0] wn,
                       input logic mdu, input logic done, input logic br);
    id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_wreg = wreg; id_m2reg = m2r; id_wn = wn;
    id_mdu = mdu; mdu_done = done; branch_taken = br;
  endtask

  // ev = {stall, bubble, flush_if, mdu_start, fwda, fwdb}
  task automatic applyStimulus(input string tag, input logic [4:0] rs, input logic [4:0] rt,
                               input logic urs, input logic urt, input logic wreg, input logic m2r,
                               input logic [4:0] wn, input logic mdu, input logic done,
                               input logic br, input logic [7:0] ev);
    exp_t e;
    @(negedge clk);
    drive(rs, rt, urs, urt, wreg, m2r, wn, mdu, done, br);
    e.tag = tag;
    e.v   = ev;
    expq.push_back(e);
    #4;
    e = expq.pop_front();
    checkOutput({e.tag, ".stall"},     32'(stall),     32'(e.v[7]));
    checkOutput({e.tag, ".bubble"},    32'(bubble),    32'(e.v[6]));
    checkOutput({e.tag, ".flush_if"},  32'(flush_if),  32'(e.v[5]));
    checkOutput({e.tag, ".mdu_start"}, 32'(mdu_start), 32'(e.v[4]));
    checkOutput({e.tag, ".fwda"},      32'(fwda),      32'(e.v[3:2]));
    checkOutput({e.tag, ".fwdb"},      32'(fwdb),      32'(e.v[1:0]));
  endtask

  task automatic nops();
    applyStimulus("nop1", 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 0, 8'b0000_0000);
    applyStimulus("nop2", 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 0, 8'b0000_0000);
  endtask

  task automatic checkShadowsZero(input string tag);
    checkOutput({tag, ".ex"},  {20'd0, 32'({dut.ex_wreg,  dut.ex_m2reg,  dut.ex_wn})},  32'd0);
    checkOutput({tag, ".mem"}, {20'd0, 32'({dut.mem_wreg, dut.mem_m2reg, dut.mem_wn})}, 32'd0);
  endtask

  initial begin
    clrn = 1'b0;
    drive(5'd7, 5'd7, 1, 1, 1, 1, 5'd7, 1, 1, 1);
    #3;
    checkOutput("rst.stall", 32'(stall), 32'd0);
    checkOutput("rst.bubble", 32'(bubble), 32'd0);
    checkOutput("rst.flush_if", 32'(flush_if), 32'd0);
    checkOutput("rst.mdu_start", 32'(mdu_start), 32'd0);
    checkOutput("rst.fwd", 32'({fwda, fwdb}), 32'd0);
    checkShadowsZero("rst");
    @(negedge clk);
    drive(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 0);
    clrn = 1'b1;

    // load followed by a dependent add
    applyStimulus("lu.lw",    5'd0, 5'd0, 0, 0, 1, 1, 5'd5, 0, 0, 0, 8'b0000_0000);
    applyStimulus("lu.stall", 5'd5, 5'd0, 1, 0, 1, 0, 5'd6, 0, 0, 0, 8'b1100_0100);
    applyStimulus("lu.fwd",   5'd5, 5'd0, 1, 0, 1, 0, 5'd6, 0, 0, 0, 8'b0000_1000);
    nops();

    // back-to-back ALU dependency on both operands
    applyStimulus("ex.add", 5'd0, 5'd0, 0, 0, 1, 0, 5'd3, 0, 0, 0, 8'b0000_0000);
    applyStimulus("ex.sub", 5'd3, 5'd3, 1, 1, 1, 0, 5'd7, 0, 0, 0, 8'b0000_0101);
    nops();

    // EX beats MEM, MEM alone, and register zero never forwards
    applyStimulus("pri.w1",  5'd0, 5'd0, 0, 0, 1, 0, 5'd4, 0, 0, 0, 8'b0000_0000);
    applyStimulus("pri.w2",  5'd0, 5'd0, 0, 0, 1, 0, 5'd4, 0, 0, 0, 8'b0000_0000);
    applyStimulus("pri.ex",  5'd4, 5'd0, 1, 0, 0, 0, 5'd0, 0, 0, 0, 8'b0000_0100);
    applyStimulus("pri.mem", 5'd4, 5'd0, 1, 0, 0, 0, 5'd0, 0, 0, 0, 8'b0000_1000);
    applyStimulus("r0.w",    5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 0, 0, 0, 8'b0000_0000);
    applyStimulus("r0.rd",   5'd0, 5'd0, 1, 0, 0, 0, 5'd0, 0, 0, 0, 8'b0000_0000);
    nops();

    // taken branch, free and under a load-use stall
    applyStimulus("br.free",  5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 1, 8'b0010_0000);
    applyStimulus("br.lw",    5'd0, 5'd0, 0, 0, 1, 1, 5'd5, 0, 0, 0, 8'b0000_0000);
    applyStimulus("br.held",  5'd5, 5'd0, 1, 0, 0, 0, 5'd0, 0, 0, 1, 8'b1100_0100);
    applyStimulus("br.flush", 5'd5, 5'd0, 1, 0, 0, 0, 5'd0, 0, 0, 1, 8'b0010_1000);
    nops();

    // mul/div with done on the fourth BUSY cycle
    applyStimulus("mdu.start", 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 1, 0, 0, 8'b1101_0000);
    applyStimulus("mdu.b1",    5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 1, 0, 0, 8'b1100_0000);
    applyStimulus("mdu.b2",    5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 1, 0, 0, 8'b1100_0000);
    applyStimulus("mdu.b3",    5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 1, 0, 0, 8'b1100_0000);
    applyStimulus("mdu.done",  5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 1, 1, 0, 8'b0000_0000);
    applyStimulus("mdu.idle",  5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 1, 0, 8'b0000_0000);
    applyStimulus("mdu.again", 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 1, 0, 0, 8'b1101_0000);
    applyStimulus("mdu.fin",   5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 1, 1, 0, 8'b0000_0000);
    nops();

    // load-use outranks a mul/div start
    applyStimulus("lumdu.lw",    5'd0, 5'd0, 0, 0, 1, 1, 5'd5, 0, 0, 0, 8'b0000_0000);
    applyStimulus("lumdu.lu",    5'd5, 5'd0, 1, 0, 0, 0, 5'd0, 1, 0, 0, 8'b1100_0100);
    applyStimulus("lumdu.start", 5'd5, 5'd0, 1, 0, 0, 0, 5'd0, 1, 0, 0, 8'b1101_1000);
    applyStimulus("lumdu.done",  5'd5, 5'd0, 1, 0, 0, 0, 5'd0, 1, 1, 0, 8'b0000_0000);
    nops();

    // asynchronous reset while BUSY
    applyStimulus("ar.lw",    5'd0, 5'd0, 0, 0, 1, 1, 5'd9, 0, 0, 0, 8'b0000_0000);
    applyStimulus("ar.start", 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 1, 0, 0, 8'b1101_0000);
    @(negedge clk);
    drive(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 1, 0, 0);
    #1;
    checkOutput("ar.busy.stall", 32'(stall), 32'd1);
    checkOutput("ar.busy.mem_wn", 32'(dut.mem_wn), 32'd9);
    clrn = 1'b0;
    #1;
    checkOutput("ar.stall", 32'(stall), 32'd0);
    checkOutput("ar.bubble", 32'(bubble), 32'd0);
    checkShadowsZero("ar");
    @(negedge clk);
    drive(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 0);
    clrn = 1'b1;
    applyStimulus("ar.quiet",   5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 0, 8'b0000_0000);
    applyStimulus("ar.restart", 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 1, 0, 0, 8'b1101_0000);
    applyStimulus("ar.fin",     5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 1, 1, 0, 8'b0000_0000);
    nops();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock.
REQ-002 SHALL have port clrn, input, 1, asynchronous active-low reset.
REQ-003 SHALL have ports id_rs and id_rt, input, 5 each, source register numbers of the instruction in ID.
REQ-004 SHALL have ports id_use_rs and id_use_rt, input, 1 each; the ID instruction reads rs / rt.
REQ-005 SHALL have ports id_wreg, id_m2reg, input, 1 each, and id_wn, input, 5; these are the ID destination controls.
REQ-006 SHALL have port id_mdu, input, 1; the ID instruction needs the multi-cycle mul/div unit.
REQ-007 SHALL have port mdu_done, input, 1; the mul/div result is ready this cycle.
REQ-008 SHALL have port branch_taken, input, 1; the branch is resolved taken in ID.
REQ-009 SHALL have port stall, output, 1; it freezes the PC and IF/ID.
REQ-010 SHALL have port bubble, output, 1; it loads zero controls into ID/EX (wreg=m2reg=wmem=0).
REQ-011 SHALL have port flush_if, output, 1; it zeroes IF/ID on the next edge.
REQ-012 SHALL have ports fwda and fwdb, output, 2 each; operand source encoded 00 regfile, 01 EX ALU result, 10 MEM result, 11 unused.
REQ-013 SHALL have port mdu_start, output, 1; a one-cycle start pulse to the mul/div unit.

Function
REQ-014 SHALL keep EX shadow registers (ex_wreg, ex_m2reg, ex_wn) and MEM shadow registers (mem_wreg, mem_m2reg, mem_wn) mirroring the pipeline registers.
REQ-015 On each clk edge, the EX shadow SHALL load 0 if bubble=1, else the id_* values; the MEM shadow SHALL load the EX shadow.
REQ-016 fwda SHALL be 01 when id_use_rs, ex_wreg, ex_wn!=0 and ex_wn==id_rs all hold.
- Else fwda SHALL be 10 when mem_wreg, mem_wn!=0 and mem_wn==id_rs all hold.
- Else fwda SHALL be 00.
- EX SHALL have priority over MEM.
REQ-017 fwdb SHALL follow REQ-016 with id_rt and id_use_rt.
REQ-018 Load-use SHALL be ex_wreg & ex_m2reg & ex_wn!=0 & ((id_use_rs & id_rs==ex_wn) | (id_use_rt & id_rt==ex_wn)).
- When load-use holds: stall=1, bubble=1 for exactly one cycle.
- After that bubble, the forward SHALL come from MEM (10).
REQ-019 The FSM SHALL have two states, IDLE and BUSY.
REQ-020 In IDLE with id_mdu=1 and no load-use: mdu_start=1, stall=1, bubble=1, and the next state SHALL be BUSY.
REQ-021 In BUSY with mdu_done=0: stall=1, bubble=1, mdu_start=0, and the FSM SHALL stay in BUSY.
REQ-022 In BUSY with mdu_done=1: stall=0, bubble=0, and the next state SHALL be IDLE, so the mdu instruction advances to EX.
REQ-023 mdu_done SHALL be ignored in IDLE.
REQ-024 In IDLE, load-use SHALL take priority over id_mdu, with no mdu_start that cycle.
REQ-025 flush_if SHALL equal branch_taken & ~stall; when a stall is active the branch is held in ID and re-evaluated.
REQ-026 mdu_start SHALL never be asserted for two consecutive cycles.

Reset
REQ-027 While clrn=0:
- all shadows SHALL be 0 and the FSM SHALL be in IDLE;
- stall, bubble, flush_if, mdu_start SHALL be 0 and fwda, fwdb SHALL be 00, regardless of inputs.
REQ-028 Reset asserted in BUSY SHALL return the FSM to IDLE asynchronously; no mdu_start SHALL follow release unless id_mdu=1.

Verification
REQ-029 The bench SHALL cover: lw $5 in ID, then add with rs=5 (id_use_rs=1) -> cycle 1: stall=1, bubble=1; cycle 2: stall=0, fwda=10.
REQ-030 The bench SHALL cover: add wn=3 followed by sub rs=3, rt=3 -> fwda=01, fwdb=01, stall=0.
REQ-031 The bench SHALL cover: wn=4 in MEM and wn=4 in EX, next rs=4 -> fwda=01; and wn=0 with wreg=1, rs=0 -> fwda=00.
REQ-032 The bench SHALL cover: id_mdu=1, mdu_done at the 4th BUSY cycle:
- mdu_start=1 for one cycle only;
- stall=1 for 4 cycles;
- on the done cycle stall=0 and the FSM returns to IDLE.
REQ-033 The bench SHALL cover: branch_taken=1 with no hazard -> flush_if=1; the same with load-use active -> flush_if=0, then flush_if=1 on the next cycle.
REQ-034 The bench SHALL cover: clrn pulsed low mid-BUSY -> stall=0 immediately and the shadows read 0.
